// File: rtl/onn_control_fsm_param.sv
// Sequencing controller for an oscillatory neural network array: load, drop,
// then repeated phase-reset / settle / stability-check until convergence or timeout.
module onn_control_fsm_param #(
  parameter int N_NEURONS     = 15,
  parameter int LOAD_CYCLES   = 60,
  parameter int RESET_PULSE   = 1,
  parameter int SETTLE_CYCLES = 17,
  parameter int STABLE_CHECKS = 1,
  parameter int MAX_ITER      = 255,
  parameter int ITER_W        = 8
) (
  input  logic                 sclk,
  input  logic                 re,
  input  logic                 load,
  input  logic                 abort,
  input  logic [N_NEURONS-1:0] state_changed,
  output logic                 re_n,
  output logic                 drop,
  output logic                 state_cheak,
  output logic                 phi_to_no,
  output logic                 timeout,
  output logic                 busy,
  output logic [ITER_W-1:0]    iter_count
);

  localparam int CMAX0 = (LOAD_CYCLES > RESET_PULSE) ? LOAD_CYCLES : RESET_PULSE;
  localparam int CMAX  = (CMAX0 > SETTLE_CYCLES) ? CMAX0 : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int STB_W = $clog2(STABLE_CHECKS + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, INIT, PULSE, SETTLE, CHECK, DONE, TOUT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [STB_W-1:0]   stb_q;
  logic [STB_W-1:0]   stb_inc;
  logic [ITER_W-1:0]  iter_q;
  logic               load_q;
  logic               start;
  logic               any_chg;
  logic               accept;

  assign start   = load & ~load_q;
  assign any_chg = |state_changed;
  assign stb_inc = stb_q + 1'b1;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE, TOUT: if (start) begin
        state_d = LOAD;
        accept  = 1'b1;
      end
      LOAD:   if (cnt_q == CNT_W'(LOAD_CYCLES - 1))   state_d = INIT;
      INIT:   state_d = PULSE;
      PULSE:  if (cnt_q == CNT_W'(RESET_PULSE - 1))   state_d = SETTLE;
      SETTLE: if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = CHECK;
      CHECK: begin
        if (!any_chg) state_d = (stb_inc == STB_W'(STABLE_CHECKS)) ? DONE : SETTLE;
        else          state_d = (iter_q == ITER_W'(MAX_ITER)) ? TOUT : PULSE;
      end
      default: state_d = IDLE;
    endcase
    // abort overrides everything, including a start in the same cycle
    if (abort) begin
      state_d = IDLE;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stb_q   <= '0;
      iter_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load;
      // shared counter: restarts on every state change, runs only in timed states
      if (state_d != state_q || !(state_q inside {LOAD, PULSE, SETTLE})) cnt_q <= '0;
      else                                                               cnt_q <= cnt_q + 1'b1;
      if (accept)                          stb_q <= '0;
      else if (state_q == CHECK && !abort) stb_q <= any_chg ? '0 : stb_inc;
      if (accept)                                     iter_q <= '0;
      else if (state_d == PULSE && state_q != PULSE)  iter_q <= iter_q + 1'b1;
    end
  end

  // outputs registered from the next state so they track the state register exactly
  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      re_n        <= 1'b0;
      drop        <= 1'b0;
      state_cheak <= 1'b0;
      phi_to_no   <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      re_n        <= (state_d == PULSE);
      drop        <= (state_d == INIT);
      state_cheak <= (state_d == CHECK);
      phi_to_no   <= (state_d == DONE);
      timeout     <= (state_d == TOUT);
      busy        <= (state_d inside {LOAD, INIT, PULSE, SETTLE, CHECK});
    end
  end

  assign iter_count = iter_q;

endmodule

// File: tb/tb_onn_control_fsm_param.sv
// Directed bench: three parameter sets share stimulus; per-cycle snapshots are
// compared against a table of hand-computed checkpoints plus abort/reset sequences.
module tb_onn_control_fsm_param;

  logic        sclk = 1'b0;
  logic        re, load, abort;
  logic [14:0] state_changed;
  logic [13:0] o0, o1, o2, cur;
  int          sel;
  int          total = 0, bad = 0;

  always #5 sclk = ~sclk;

  logic        rn0, dr0, ck0, ph0, to0, bs0; logic [7:0] it0;
  logic        rn1, dr1, ck1, ph1, to1, bs1; logic [7:0] it1;
  logic        rn2, dr2, ck2, ph2, to2, bs2; logic [7:0] it2;

  onn_control_fsm_param dut0 (.sclk(sclk), .re(re), .load(load), .abort(abort),
    .state_changed(state_changed), .re_n(rn0), .drop(dr0), .state_cheak(ck0),
    .phi_to_no(ph0), .timeout(to0), .busy(bs0), .iter_count(it0));
  onn_control_fsm_param #(.MAX_ITER(3)) dut1 (.sclk(sclk), .re(re), .load(load), .abort(abort),
    .state_changed(state_changed), .re_n(rn1), .drop(dr1), .state_cheak(ck1),
    .phi_to_no(ph1), .timeout(to1), .busy(bs1), .iter_count(it1));
  onn_control_fsm_param #(.STABLE_CHECKS(2)) dut2 (.sclk(sclk), .re(re), .load(load), .abort(abort),
    .state_changed(state_changed), .re_n(rn2), .drop(dr2), .state_cheak(ck2),
    .phi_to_no(ph2), .timeout(to2), .busy(bs2), .iter_count(it2));

  // bundle order: {re_n, drop, state_cheak, phi_to_no, timeout, busy, iter_count}
  assign o0  = {rn0, dr0, ck0, ph0, to0, bs0, it0};
  assign o1  = {rn1, dr1, ck1, ph1, to1, bs1, it1};
  assign o2  = {rn2, dr2, ck2, ph2, to2, bs2, it2};
  assign cur = (sel == 0) ? o0 : (sel == 1) ? o1 : o2;

  typedef struct {
    int         scn;
    int         cyc;
    logic [13:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [13:0] snap [0:199];
  int          pulses;

  function automatic logic [13:0] ex(logic rn, logic dr, logic ck, logic ph,
                                     logic tout, logic bs, int it);
    logic [7:0] i8;
    i8 = it[7:0];
    return {rn, dr, ck, ph, tout, bs, i8};
  endfunction

  task automatic check(string name, logic [13:0] act, logic [13:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got re_n/drop/chk/phi/tout/busy=%b iter=%0d, want %b iter=%0d",
               name, act[13:8], act[7:0], exp_v[13:8], exp_v[7:0]);
    end
  endtask

  task automatic tick();
    @(posedge sclk); #1;
  endtask

  task automatic do_reset();
    re = 1'b1; load = 1'b0; abort = 1'b0; state_changed = '0;
    repeat (2) @(posedge sclk);
    #1 re = 1'b0;
    tick();
  endtask

  // starts a run (cycle 0 = first LOAD cycle) and records ncyc snapshots
  task automatic run_scn(int s, int ncyc);
    do_reset();
    load = 1'b1;
    tick();
    pulses = 0;
    for (int k = 0; k < ncyc; k++) begin
      snap[k] = cur;
      if (cur[13]) pulses++;
      if (s == 1 && k == 0) load = 1'b0;
      case (s)
        2:       state_changed = (k == 79 || k == 98) ? 15'h0004 : 15'h0000;
        3:       state_changed = 15'h0001;
        default: state_changed = 15'h0000;
      endcase
      tick();
    end
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].scn == s)
        check($sformatf("scn%0d@%0d", s, tbl[i].cyc), snap[tbl[i].cyc], tbl[i].exp);
  endtask

  initial begin
    logic        ok;
    logic [13:0] zero14;
    zero14 = '0;
    sel = 0;

    // scenario 1: defaults, converge on first check
    tbl.push_back('{1,   0, ex(0,0,0,0,0,1,0)});
    tbl.push_back('{1,  59, ex(0,0,0,0,0,1,0)});
    tbl.push_back('{1,  60, ex(0,1,0,0,0,1,0)});
    tbl.push_back('{1,  61, ex(1,0,0,0,0,1,1)});
    tbl.push_back('{1,  62, ex(0,0,0,0,0,1,1)});
    tbl.push_back('{1,  78, ex(0,0,0,0,0,1,1)});
    tbl.push_back('{1,  79, ex(0,0,1,0,0,1,1)});
    tbl.push_back('{1,  80, ex(0,0,0,1,0,0,1)});
    tbl.push_back('{1, 150, ex(0,0,0,1,0,0,1)});
    // scenario 2: two unstable checks then converge
    tbl.push_back('{2,  79, ex(0,0,1,0,0,1,1)});
    tbl.push_back('{2,  80, ex(1,0,0,0,0,1,2)});
    tbl.push_back('{2,  98, ex(0,0,1,0,0,1,2)});
    tbl.push_back('{2,  99, ex(1,0,0,0,0,1,3)});
    tbl.push_back('{2, 116, ex(0,0,0,0,0,1,3)});
    tbl.push_back('{2, 117, ex(0,0,1,0,0,1,3)});
    tbl.push_back('{2, 118, ex(0,0,0,1,0,0,3)});
    // scenario 3: MAX_ITER=3, never stable
    tbl.push_back('{3,  98, ex(0,0,1,0,0,1,2)});
    tbl.push_back('{3, 117, ex(0,0,1,0,0,1,3)});
    tbl.push_back('{3, 118, ex(0,0,0,0,1,0,3)});
    tbl.push_back('{3, 190, ex(0,0,0,0,1,0,3)});
    // scenario 4: STABLE_CHECKS=2, re-check without new pulse
    tbl.push_back('{4,  79, ex(0,0,1,0,0,1,1)});
    tbl.push_back('{4,  80, ex(0,0,0,0,0,1,1)});
    tbl.push_back('{4,  96, ex(0,0,0,0,0,1,1)});
    tbl.push_back('{4,  97, ex(0,0,1,0,0,1,1)});
    tbl.push_back('{4,  98, ex(0,0,0,1,0,0,1)});

    do_reset();
    check("reset_state", o0, zero14);

    sel = 0; run_scn(1, 160);
    sel = 0; run_scn(2, 130);
    sel = 1; run_scn(3, 200);
    check("maxiter_pulses", {6'b0, pulses[7:0]}, 14'd3);
    sel = 2; run_scn(4, 120);
    check("stable2_pulses", {6'b0, pulses[7:0]}, 14'd1);

    // abort at cycle 30 with load held high
    sel = 0;
    do_reset();
    load = 1'b1; tick();
    repeat (30) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_idle", cur, zero14);
    ok = 1'b1;
    repeat (40) begin tick(); if (cur !== zero14) ok = 1'b0; end
    check("abort_no_retrigger", {13'b0, ok}, 14'd1);
    load = 1'b0; tick();
    load = 1'b1; tick();
    check("restart_after_abort", cur, ex(0,0,0,0,0,1,0));
    repeat (85) tick();
    check("restart_done", cur, ex(0,0,0,1,0,0,1));
    load = 1'b0; tick();
    load = 1'b1; tick();
    check("restart_from_done", cur, ex(0,0,0,0,0,1,0));

    // asynchronous reset mid-SETTLE
    do_reset();
    load = 1'b1; tick(); load = 1'b0;
    repeat (70) tick();
    check("pre_reset_settle", cur, ex(0,0,0,0,0,1,1));
    re = 1'b1; #1;
    check("async_reset", cur, zero14);
    @(posedge sclk); #1 re = 1'b0;
    ok = 1'b1;
    repeat (20) begin tick(); if (cur !== zero14) ok = 1'b0; end
    check("idle_after_reset", {13'b0, ok}, 14'd1);
    load = 1'b1; tick();
    check("start_after_reset", cur, ex(0,0,0,0,0,1,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onn_control_fsm_param.md
# onn_control_fsm_param

Parametrised sequencing controller for an N-neuron oscillatory neural network (ONN) array. It loads the initial pattern and drops it into the neurons. It then repeats phase-reset / settle / stability-check iterations until no neuron changes state or an iteration limit is hit, and flags convergence for phase-to-number readout. It sits between the host load logic and the neuron array, and adds configurable timing, multi-check convergence, timeout, abort and an iteration count.

## Interface
- N_NEURONS, 15, width of `state_changed`.
- LOAD_CYCLES, 60, cycles spent in LOAD (≥1).
- RESET_PULSE, 1, `re_n` pulse width in cycles (≥1).
- SETTLE_CYCLES, 17, settle window after each pulse (≥1).
- STABLE_CHECKS, 1, consecutive stable checks required for convergence (≥1).
- MAX_ITER, 255, maximum `re_n` pulses per run (1 ≤ MAX_ITER < 2^ITER_W).
- ITER_W, 8, width of `iter_count`.

Ports:
- sclk  in  1  clock, all logic on rising edge.
- re  in  1  reset, asynchronous, active-high.
- load  in  1  run request; only a rising edge (load high, registered load_q low) starts a run.
- abort  in  1  synchronous abort to IDLE.
- state_changed  in  N_NEURONS  per-neuron "state changed this window" flags.
- re_n  out  1  neuron phase-reset pulse.
- drop  out  1  pattern drop strobe.
- state_cheak  out  1  stability-check strobe.
- phi_to_no  out  1  converged; readout enable.
- timeout  out  1  run ended without convergence.
- busy  out  1  run in progress (LOAD..CHECK).
- iter_count  out  ITER_W  `re_n` pulses issued in current/last run.

## Operation
- States: IDLE, LOAD, INIT, PULSE, SETTLE, CHECK, DONE, TOUT. A single shared cycle counter and a stable counter are used.
- Outputs are registered. Each output is high exactly in the cycles the state register holds the named state:
  - drop = INIT
  - re_n = PULSE
  - state_cheak = CHECK
  - phi_to_no = DONE
  - timeout = TOUT
  - busy = LOAD/INIT/PULSE/SETTLE/CHECK
- Reset (`re` high): state IDLE, every output 0, iter_count 0, counters 0, load_q 0. Takes effect immediately, in any state.
- Transitions:
  - IDLE: start → LOAD. iter_count and stable count are cleared on start.
  - LOAD: LOAD_CYCLES cycles → INIT.
  - INIT: 1 cycle → PULSE.
  - PULSE: RESET_PULSE cycles → SETTLE. iter_count increments on entry.
  - SETTLE: SETTLE_CYCLES cycles → CHECK.
  - CHECK: 1 cycle. Evaluate the OR-reduction of state_changed sampled in this cycle:
    - Zero: stable+1. If stable+1 == STABLE_CHECKS → DONE; else → SETTLE, with no new pulse.
    - Nonzero: stable cleared. If iter_count == MAX_ITER → TOUT; else → PULSE.
  - DONE and TOUT: held until start → LOAD, or abort → IDLE.
- start is ignored while busy. A load held high never retriggers a run.
- abort takes priority over every other transition. The next state is IDLE; busy, phi_to_no, timeout, re_n, drop and state_cheak all go low. iter_count holds its value.
- abort and start in the same IDLE cycle: abort wins, no run.
- iter_count never wraps; MAX_ITER bounds it.

## Timing
- Cycle 0 is the first LOAD cycle, i.e. the cycle after the edge that samples start.
- drop is high in cycle LOAD_CYCLES. re_n is high in cycles LOAD_CYCLES+1 … LOAD_CYCLES+RESET_PULSE.
- First state_cheak is at cycle C1 = LOAD_CYCLES+1+RESET_PULSE+SETTLE_CYCLES (79 with defaults).
- Iteration period is RESET_PULSE+SETTLE_CYCLES+1 (19 with defaults). A stable-but-unconfirmed re-check period is SETTLE_CYCLES+1.
- DONE/TOUT is entered in the cycle immediately after the deciding CHECK.
- The abort or reset response is visible on outputs in the next cycle (reset: immediately).

## Test plan
- Defaults, load pulse, state_changed=0 → drop@60, re_n@61, state_cheak@79, phi_to_no high from 80 and held, busy low from 80, iter_count=1.
- Defaults, state_changed=15'h0004 at checks 79 and 98, then 0 → re_n@61,80,99; state_cheak@79,98,117; phi_to_no@118; iter_count=3; timeout=0.
- MAX_ITER=3, state_changed=15'h0001 constant → checks at 79, 98, 117; timeout high from 118; phi_to_no=0; iter_count=3; no fourth re_n.
- STABLE_CHECKS=2, state_changed=0 → state_cheak@79 and 97, single re_n@61, phi_to_no from 98.
- Defaults, abort at cycle 30 with load still high → IDLE at 31, all outputs 0, no restart until load falls and rises again. A second rising edge in DONE restarts with iter_count cleared.
- re asserted mid-SETTLE (cycle 70) → all outputs and iter_count 0 immediately. After release, the block stays IDLE with no activity until a load rising edge.
